irq_controller: RTL

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Four-source priority interrupt controller with a 3-byte register window.
// Optional feature: define IRQ_READBACK_EN to make pending/mask readable on BUS_DATA.
module irq_controller #(
   parameter logic [7:0] IrqBaseAddr = 8'hE0,
   parameter logic [3:0] InitialMask = 4'hF
) (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] BUS_DATA,
   input  logic [7:0] BUS_ADDR,
   input  logic       BUS_WE,
   input  logic [3:0] IRQ_IN,
   output logic [3:0] SRC_ACK,
   output logic       CPU_IRQ,
   output logic [1:0] CPU_IRQ_ID,
   input  logic       CPU_IRQ_ACK
);

   localparam logic [7:0] AddrPend = IrqBaseAddr;
   localparam logic [7:0] AddrMask = IrqBaseAddr + 8'd1;
   localparam logic [7:0] AddrClr  = IrqBaseAddr + 8'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RAISE = 2'd1,
      GAP   = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] irq_q, irq_d;
   logic       armed_q, armed_d;
   logic [3:0] pending_q, pending_d;
   logic [3:0] mask_q, mask_d;
   logic [1:0] id_q, id_d;
   logic [3:0] src_ack_q, src_ack_d;

   logic [3:0] rise;
   logic [3:0] bus_clr;
   logic [3:0] ack_clr;
   logic       wr_mask;
   logic       wr_clr;
   logic       unused_bus_hi;

   assign unused_bus_hi = ^BUS_DATA[7:4];

   function automatic logic [1:0] lowest_set(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // NOTE: every always_comb output gets a default first, so no path leaves a latch.
   always_comb begin
      wr_mask   = BUS_WE && (BUS_ADDR == AddrMask);
      wr_clr    = BUS_WE && (BUS_ADDR == AddrClr);

      // armed_q masks the first edge after reset so a level already high is not an edge.
      rise      = IRQ_IN & ~irq_q & {4{armed_q}};
      irq_d     = IRQ_IN;
      armed_d   = 1'b1;
      mask_d    = wr_mask ? BUS_DATA[3:0] : mask_q;
      bus_clr   = wr_clr ? BUS_DATA[3:0] : 4'h0;
      ack_clr   = 4'h0;
      state_d   = state_q;
      id_d      = id_q;
      src_ack_d = 4'h0;

      unique case (state_q)
         IDLE: begin
            if ((pending_q & mask_q) != 4'h0) begin
               id_d    = lowest_set(pending_q & mask_q);
               state_d = RAISE;
            end
         end
         RAISE: begin
            if (CPU_IRQ_ACK) begin
               ack_clr   = 4'b0001 << id_q;
               src_ack_d = 4'b0001 << id_q;
               state_d   = GAP;
            end
         end
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Set wins over both software clear and acknowledge clear.
      pending_d = (pending_q & ~(bus_clr | ack_clr)) | rise;

      if ((state_q == RAISE) && !CPU_IRQ_ACK && (!pending_d[id_q] || !mask_d[id_q])) begin
         state_d = IDLE;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= IDLE;
         irq_q     <= 4'h0;
         armed_q   <= 1'b0;
         pending_q <= 4'h0;
         mask_q    <= InitialMask;
         id_q      <= 2'd0;
         src_ack_q <= 4'h0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_d;
         armed_q   <= armed_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         id_q      <= id_d;
         src_ack_q <= src_ack_d;
      end
   end

   assign CPU_IRQ    = (state_q == RAISE);
   assign CPU_IRQ_ID = id_q;
   assign SRC_ACK    = src_ack_q;

`ifdef IRQ_READBACK_EN
   typedef enum logic [1:0] {
      RD_NONE = 2'd0,
      RD_PEND = 2'd1,
      RD_MASK = 2'd2
   } rd_sel_e;

   rd_sel_e rd_sel_q, rd_sel_d;

   always_comb begin
      rd_sel_d = RD_NONE;
      if (!BUS_WE) begin
         if (BUS_ADDR == AddrPend)      rd_sel_d = RD_PEND;
         else if (BUS_ADDR == AddrMask) rd_sel_d = RD_MASK;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) rd_sel_q <= RD_NONE;
      else        rd_sel_q <= rd_sel_d;
   end

   assign BUS_DATA = (rd_sel_q == RD_PEND) ? {4'h0, pending_q} :
                     (rd_sel_q == RD_MASK) ? {4'h0, mask_q}    : 8'hzz;
`else
   assign BUS_DATA = 8'hzz;
`endif

endmodule
